// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the NLP-16AF shared memory port.
// The arbiter connects through 'slave'; the requesters and memory side use 'master'.
interface mem_bus_arbiter_if;
  logic        i_if_req;
  logic [15:0] i_if_addr;
  logic        o_if_ack;
  logic [15:0] o_if_rdata;

  logic        i_dt_req;
  logic        i_dt_we;
  logic [15:0] i_dt_addr;
  logic [15:0] i_dt_wdata;
  logic        o_dt_ack;
  logic [15:0] o_dt_rdata;

  logic        i_dbg_req;
  logic        i_dbg_we;
  logic [15:0] i_dbg_addr;
  logic [15:0] i_dbg_wdata;
  logic        o_dbg_ack;
  logic [15:0] o_dbg_rdata;

  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        o_mem_re;
  logic        o_mem_we;
  logic [15:0] i_mem_rdata;
  logic        o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    input  i_dt_req, i_dt_we, i_dt_addr, i_dt_wdata,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    input  i_mem_rdata,
    output o_if_ack, o_if_rdata,
    output o_dt_ack, o_dt_rdata,
    output o_dbg_ack, o_dbg_rdata,
    output o_mem_addr, o_mem_wdata, o_mem_re, o_mem_we, o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    output i_dt_req, i_dt_we, i_dt_addr, i_dt_wdata,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    output i_mem_rdata,
    input  o_if_ack, o_if_rdata,
    input  o_dt_ack, o_dt_rdata,
    input  o_dbg_ack, o_dbg_rdata,
    input  o_mem_addr, o_mem_wdata, o_mem_re, o_mem_we, o_busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter for the single 16-bit memory port: debug > data > fetch,
// with fetch promoted over data after STARVE_LIMIT lost arbitrations.

// Per-requester response register: one-cycle ack and held read data.
module mem_bus_arbiter_port (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        done_i,
  input  logic        we_i,
  input  logic [15:0] rdata_i,
  output logic        ack_o,
  output logic [15:0] rdata_o
);
  logic        ack_q;
  logic [15:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (done_i && !we_i) rdata_d = rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= done_i;
      rdata_q <= rdata_d;
    end
  end

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
endmodule

module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned NUM_REQ = 3;
  localparam logic [1:0]  REQ_IF  = 2'd0;
  localparam logic [1:0]  REQ_DT  = 2'd1;
  localparam logic [1:0]  REQ_DBG = 2'd2;

  typedef enum logic {S_IDLE, S_ACC} state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  req_t   [NUM_REQ-1:0] req_in;
  logic   [NUM_REQ-1:0] req_vld;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] starve_q, starve_d;
  logic [1:0] owner_q;
  req_t       cur_q;

  logic [1:0] gnt_idx;
  req_t       gnt_req;
  logic       promote;
  logic       done;

  logic [NUM_REQ-1:0]       done_vec;
  logic [NUM_REQ-1:0]       ack_w;
  logic [NUM_REQ-1:0][15:0] rdata_w;

  // Fetch is read-only, so its write fields are tied off.
  assign req_in[REQ_IF]  = '{we: 1'b0, addr: bus.i_if_addr, wdata: 16'h0000};
  assign req_in[REQ_DT]  = '{we: bus.i_dt_we, addr: bus.i_dt_addr, wdata: bus.i_dt_wdata};
  assign req_in[REQ_DBG] = '{we: bus.i_dbg_we, addr: bus.i_dbg_addr, wdata: bus.i_dbg_wdata};
  assign req_vld         = {bus.i_dbg_req, bus.i_dt_req, bus.i_if_req};

  assign promote = (starve_q >= 4'(STARVE_LIMIT));

  always_comb begin
    gnt_idx = REQ_IF;
    if (req_vld[REQ_DBG])                 gnt_idx = REQ_DBG;
    else if (promote && req_vld[REQ_IF])  gnt_idx = REQ_IF;
    else if (req_vld[REQ_DT])             gnt_idx = REQ_DT;
  end

  always_comb begin
    gnt_req = req_in[REQ_IF];
    case (gnt_idx)
      REQ_DT:  gnt_req = req_in[REQ_DT];
      REQ_DBG: gnt_req = req_in[REQ_DBG];
      default: gnt_req = req_in[REQ_IF];
    endcase
  end

  // A fetch request still pending after losing a grant counts as one starved round.
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (!req_vld[REQ_IF] || gnt_idx == REQ_IF) starve_d = '0;
      else if (starve_q != 4'hF)                 starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      owner_q  <= REQ_IF;
      cur_q    <= '0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        S_IDLE: begin
          if (|req_vld) begin
            owner_q <= gnt_idx;
            cur_q   <= gnt_req;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          if (cnt_q != 4'd0) cnt_q   <= cnt_q - 4'd1;
          else               state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done = (state_q == S_ACC) && (cnt_q == 4'd0);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    assign done_vec[g] = done && (owner_q == 2'(g));
    mem_bus_arbiter_port u_port (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .done_i  (done_vec[g]),
      .we_i    (cur_q.we),
      .rdata_i (bus.i_mem_rdata),
      .ack_o   (ack_w[g]),
      .rdata_o (rdata_w[g])
    );
  end

  // Strobes come straight off the state register so an async reset drops them at once.
  assign bus.o_busy      = (state_q == S_ACC);
  assign bus.o_mem_re    = (state_q == S_ACC) && !cur_q.we;
  assign bus.o_mem_we    = (state_q == S_ACC) &&  cur_q.we;
  assign bus.o_mem_addr  = cur_q.addr;
  assign bus.o_mem_wdata = cur_q.wdata;

  assign bus.o_if_ack    = ack_w[REQ_IF];
  assign bus.o_dt_ack    = ack_w[REQ_DT];
  assign bus.o_dbg_ack   = ack_w[REQ_DBG];
  assign bus.o_if_rdata  = rdata_w[REQ_IF];
  assign bus.o_dt_rdata  = rdata_w[REQ_DT];
  assign bus.o_dbg_rdata = rdata_w[REQ_DBG];
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single 16-bit memory port of the NLP-16AF core among three requesters: instruction fetch (IF1/IF2/IF3 words), data access (load/store/push/pop) and the debug port. It sits between the instruction decoder/datapath and the memory interface. It grants one requester at a time under fixed priority with a fetch anti-starvation guard, sequences a fixed wait-state access, and returns read data with a one-cycle acknowledge.

## Interface
- WAIT_CYCLES, 1: extra memory wait states per access (0..15).
- STARVE_LIMIT, 4: consecutive lost arbitrations after which fetch is promoted above data (1..15).
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset: one clock; asynchronous, active-low.
- i_if_req  in  1  fetch request (read only).
- i_if_addr  in  16  fetch word address.
- o_if_ack  out  1  fetch done, one-cycle pulse.
- o_if_rdata  out  16  fetch read data, valid while o_if_ack, held afterwards.
- i_dt_req  in  1  data request.
- i_dt_we  in  1  data write enable (1 = store/push).
- i_dt_addr  in  16  data address.
- i_dt_wdata  in  16  data write value.
- o_dt_ack  out  1  data done, one-cycle pulse.
- o_dt_rdata  out  16  data read value, valid while o_dt_ack, held afterwards.
- i_dbg_req, i_dbg_we, i_dbg_addr[15:0], i_dbg_wdata[15:0]  in  debug request, same meaning as data.
- o_dbg_ack  out  1, o_dbg_rdata  out  16  debug done / read data.
- o_mem_addr  out  16  memory address.
- o_mem_wdata  out  16  memory write data.
- o_mem_re  out  1  memory read strobe.
- o_mem_we  out  1  memory write strobe.
- i_mem_rdata  in  16  memory read data, valid in the last ACC cycle.
- o_busy  out  1  high while in ACC.

## Operation
- States: IDLE, ACC. Reset enters IDLE.
- IDLE: if any request is high, select the winner, latch owner, addr, we and wdata, load cnt = WAIT_CYCLES, and go to ACC. With no request, stay in IDLE.
- Priority: debug > data > fetch. When starve_cnt >= STARVE_LIMIT, the order is debug > fetch > data.
- starve_cnt (4 bits, saturating):
  - Increments when a grant is made while i_if_req is high and fetch loses.
  - Clears on a fetch grant, or whenever i_if_req is low in IDLE.
- ACC:
  - o_mem_addr and o_mem_wdata are driven from the latched values.
  - o_mem_re = !we and o_mem_we = we, held for the whole of ACC.
  - If cnt != 0, decrement cnt. If cnt == 0, at the edge: capture i_mem_rdata into the owner's rdata register (reads only; writes leave it unchanged), pulse the owner's ack, and go to IDLE.
- Requesters hold req, addr, we and wdata stable until ack. Changes during ACC are ignored because the values are latched.
- A req still high in the ack cycle is a new request and is arbitrated in that same IDLE cycle.
- A req dropped mid-ACC does not abort the access. It completes and the ack is still pulsed.
- No internal error detection; out-of-range parameters are not supported.

## Timing
- Reset values:
  - State IDLE, cnt 0, starve_cnt 0.
  - All acks 0, all rdata 0.
  - o_mem_re 0, o_mem_we 0, o_mem_addr 0, o_mem_wdata 0, o_busy 0.
- Outputs are registered; memory strobes are decoded from the state register only.
- Latency: a request sampled in IDLE at edge E gives memory strobes in cycles E+1..E+1+WAIT_CYCLES. Ack and rdata are visible in the cycle after edge E+2+WAIT_CYCLES.
  - Total: WAIT_CYCLES+2 cycles from the request cycle to the ack cycle.
- Throughput: one access per WAIT_CYCLES+2 cycles with back-to-back requests. The ack cycle doubles as the next IDLE arbitration cycle.
- Simultaneous requests are resolved only in IDLE. Requests arriving during ACC wait.
- Asynchronous reset mid-ACC: strobes drop immediately, no ack is issued, and the state returns to IDLE. The requester must reissue.

## Test plan
- Single fetch read, WAIT_CYCLES=1, i_mem_rdata=16'hA55A at addr 16'h0100:
  - o_mem_re high for 2 cycles with o_mem_addr=16'h0100.
  - o_if_ack pulses 3 cycles after the request cycle with o_if_rdata=16'hA55A.
  - o_dt_ack and o_dbg_ack stay 0.
- Data write of 16'h1234 to 16'h7FFE: o_mem_we high with the latched addr/data for WAIT_CYCLES+1 cycles, o_dt_ack pulses once, o_dt_rdata unchanged.
- All three requests in the same cycle, held high: grant order is debug, data, fetch.
  - Each ack is spaced WAIT_CYCLES+2 cycles apart, with no idle gap between them.
- Starvation, STARVE_LIMIT=4, fetch and data continuously high:
  - Data wins 4 times.
  - Fetch wins the 5th arbitration.
  - starve_cnt clears and data wins next.
- Data req drops one cycle into ACC: the access still completes and o_dt_ack pulses once; no second access starts.
- Reset asserted during ACC of a read: o_mem_re goes to 0 without waiting for an edge, no ack pulses, and o_busy is 0. After release a fresh request completes normally.
